hcm_row_allocator: RTL and testbench

Upstream feeder for the HCM stage. Accepts a stream of SSIDs per event and assigns each distinct SSID a compact HCM row index in arrival order, from a small associative table. Drives the HCM write interface (writeRow, rowToWrite, SSIDIsNew). Buffers input in a shallow FIFO while HCM is busy and clears its table at event boundaries.

---
 rtl/hcm_row_allocator_pkg.sv | 7 +
 rtl/hcm_row_allocator_ssid_fifo.sv | 36 +++
 rtl/hcm_row_allocator.sv | 100 ++++++++++
 tb/tb_hcm_row_allocator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hcm_row_allocator_pkg.sv
// hcm_row_allocator_pkg: shared widths and FSM encoding for the HCM row allocator.
package hcm_row_allocator_pkg;
    localparam int SSIDBITS         = 16;
    localparam int ROWINDEXBITS_HCM = 16;
    localparam int NROWS_HCM        = 1 << ROWINDEXBITS_HCM;
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_t;
endpackage

// File: rtl/hcm_row_allocator_ssid_fifo.sv
// hcm_row_allocator_ssid_fifo: shallow synchronous FIFO with a combinational head.
module hcm_row_allocator_ssid_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic             do_push, do_pop;
    assign empty   = wp == rp;
    assign full    = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign dout    = mem[rp[AW-1:0]];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/hcm_row_allocator.sv
// hcm_row_allocator: assigns each distinct SSID of an event a compact HCM row in arrival order.
module hcm_row_allocator #(
    parameter int SSIDBITS         = hcm_row_allocator_pkg::SSIDBITS,
    parameter int ROWINDEXBITS_HCM = hcm_row_allocator_pkg::ROWINDEXBITS_HCM,
    parameter int NENTRIES         = 16,
    parameter int FIFODEPTH        = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        SSIDValid,
    input  logic [SSIDBITS-1:0]         SSIDIn,
    output logic                        SSIDReady,
    input  logic                        eventEnd,
    input  logic                        hcmBusy,
    output logic                        writeRow,
    output logic [ROWINDEXBITS_HCM-1:0] rowToWrite,
    output logic                        SSIDIsNew,
    output logic [ROWINDEXBITS_HCM:0]   nRowsUsed,
    output logic                        overflow,
    output logic                        eventDone
);
    import hcm_row_allocator_pkg::*;
    localparam int IW = NENTRIES > 1 ? $clog2(NENTRIES) : 1;
    state_t                    state, state_nx;
    logic                      up, push, pop, empty, full, hit, tab_full, alloc;
    logic [SSIDBITS-1:0]       head;
    logic [IW-1:0]             hit_idx;
    logic [NENTRIES-1:0]       valid;
    logic [SSIDBITS-1:0]       tags [NENTRIES];
    logic [ROWINDEXBITS_HCM:0] cnt;
    // up holds SSIDReady low until the first edge after reset release
    assign SSIDReady = up & (state == RUN) & ~full;
    assign push      = SSIDValid & SSIDReady;
    assign pop       = ~empty & ~hcmBusy;
    assign tab_full  = cnt == (ROWINDEXBITS_HCM+1)'(NENTRIES);
    assign alloc     = pop & (state != CLEAR) & ~hit & ~tab_full;
    assign nRowsUsed = cnt;
    hcm_row_allocator_ssid_fifo #(.WIDTH(SSIDBITS), .DEPTH(FIFODEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .din(SSIDIn), .dout(head), .full(full), .empty(empty)
    );
    // rows are handed out in entry order, so an entry's index is its row
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NENTRIES; i++) begin
            if (valid[i] && tags[i] == head) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end
    always_comb begin
        state_nx = state;
        state_nx = state == RUN   ? (eventEnd ? DRAIN : RUN) :
                   state == DRAIN ? (empty ? CLEAR : DRAIN) : RUN;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up         <= 1'b0;
            valid      <= '0;
            cnt        <= '0;
            writeRow   <= 1'b0;
            rowToWrite <= '0;
            SSIDIsNew  <= 1'b0;
            overflow   <= 1'b0;
            eventDone  <= 1'b0;
        end else begin
            up        <= 1'b1;
            writeRow  <= 1'b0;
            eventDone <= state == CLEAR;
            if (state == CLEAR) begin
                valid    <= '0;
                cnt      <= '0;
                overflow <= 1'b0;
            end else if (pop) begin
                if (hit) begin
                    writeRow   <= 1'b1;
                    rowToWrite <= ROWINDEXBITS_HCM'(hit_idx);
                    SSIDIsNew  <= 1'b0;
                end else if (!tab_full) begin
                    writeRow         <= 1'b1;
                    rowToWrite       <= cnt[ROWINDEXBITS_HCM-1:0];
                    SSIDIsNew        <= 1'b1;
                    valid[cnt[IW-1:0]] <= 1'b1;
                    cnt              <= cnt + 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (alloc) tags[cnt[IW-1:0]] <= head;
    end
endmodule

// File: tb/tb_hcm_row_allocator.sv
// tb_hcm_row_allocator: directed scenarios for the HCM row allocator with hand-computed expectations.
module tb_hcm_row_allocator;
    logic        clk = 1'b0, reset = 1'b0, SSIDValid = 1'b0, eventEnd = 1'b0, hcmBusy = 1'b0;
    logic [15:0] SSIDIn = '0;
    logic        SSIDReady, writeRow, SSIDIsNew, overflow, eventDone;
    logic [15:0] rowToWrite;
    logic [16:0] nRowsUsed;
    int          checks = 0, errors = 0;
    int          src[$], wr_row[$], wr_cyc[$];
    logic        wr_new[$];
    int          acc_at_release;
    logic        rdy_at_release;

    hcm_row_allocator #(.SSIDBITS(16), .ROWINDEXBITS_HCM(16), .NENTRIES(16), .FIFODEPTH(4)) dut (
        .clk(clk), .reset(reset), .SSIDValid(SSIDValid), .SSIDIn(SSIDIn), .SSIDReady(SSIDReady),
        .eventEnd(eventEnd), .hcmBusy(hcmBusy), .writeRow(writeRow), .rowToWrite(rowToWrite),
        .SSIDIsNew(SSIDIsNew), .nRowsUsed(nRowsUsed), .overflow(overflow), .eventDone(eventDone)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Offers src[] with valid/ready, holds hcmBusy for busy_cyc cycles, logs every write.
    task automatic stream(input int busy_cyc, input int ncyc);
        int idx = 0;
        wr_row.delete(); wr_new.delete(); wr_cyc.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (writeRow) begin
                wr_row.push_back(int'(rowToWrite)); wr_new.push_back(SSIDIsNew); wr_cyc.push_back(c);
            end
            if (c == busy_cyc) begin acc_at_release = idx; rdy_at_release = SSIDReady; end
            hcmBusy   = c < busy_cyc;
            SSIDValid = idx < src.size();
            SSIDIn    = SSIDValid ? 16'(src[idx]) : 16'd0;
            if (SSIDValid && SSIDReady) idx++;
        end
        SSIDValid = 1'b0; hcmBusy = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (writeRow !== 1'b0) begin errors++; $display("FAIL reset_writeRow got %0d exp 0", writeRow); end
        checks++; if (rowToWrite !== 16'd0) begin errors++; $display("FAIL reset_rowToWrite got %0d exp 0", rowToWrite); end
        checks++; if (SSIDIsNew !== 1'b0) begin errors++; $display("FAIL reset_SSIDIsNew got %0d exp 0", SSIDIsNew); end
        checks++; if (nRowsUsed !== 17'd0) begin errors++; $display("FAIL reset_nRowsUsed got %0d exp 0", nRowsUsed); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0d exp 0", overflow); end
        checks++; if (eventDone !== 1'b0) begin errors++; $display("FAIL reset_eventDone got %0d exp 0", eventDone); end
        checks++; if (SSIDReady !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %0d exp 0", SSIDReady); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (SSIDReady !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %0d exp 1", SSIDReady); end
        checks++; if (writeRow !== 1'b0) begin errors++; $display("FAIL reset_writeRow_after got %0d exp 0", writeRow); end
    endtask

    task automatic test_basic;
        int er[3] = '{0, 1, 0};
        logic en[3] = '{1'b1, 1'b1, 1'b0};
        src = '{5, 9, 5};
        stream(0, 8);
        checks++; if (wr_row.size() != 3) begin errors++; $display("FAIL basic_count got %0d exp 3", wr_row.size()); end
        for (int i = 0; i < 3 && i < wr_row.size(); i++) begin
            checks++; if (wr_row[i] != er[i]) begin errors++; $display("FAIL basic_row%0d got %0d exp %0d", i, wr_row[i], er[i]); end
            checks++; if (wr_new[i] !== en[i]) begin errors++; $display("FAIL basic_new%0d got %0d exp %0d", i, wr_new[i], en[i]); end
            checks++; if (wr_cyc[i] != 2 + i) begin errors++; $display("FAIL basic_cycle%0d got %0d exp %0d", i, wr_cyc[i], 2 + i); end
        end
        checks++; if (nRowsUsed !== 17'd2) begin errors++; $display("FAIL basic_nRowsUsed got %0d exp 2", nRowsUsed); end
    endtask

    task automatic test_busy;
        do_reset();
        src = '{1, 2, 3, 4, 5, 6};
        stream(8, 20);
        checks++; if (acc_at_release != 4) begin errors++; $display("FAIL busy_accepted got %0d exp 4", acc_at_release); end
        checks++; if (rdy_at_release !== 1'b0) begin errors++; $display("FAIL busy_ready got %0d exp 0", rdy_at_release); end
        checks++; if (wr_row.size() != 6) begin errors++; $display("FAIL busy_count got %0d exp 6", wr_row.size()); end
        for (int i = 0; i < 6 && i < wr_row.size(); i++) begin
            checks++; if (wr_row[i] != i) begin errors++; $display("FAIL busy_row%0d got %0d exp %0d", i, wr_row[i], i); end
            checks++; if (wr_new[i] !== 1'b1) begin errors++; $display("FAIL busy_new%0d got %0d exp 1", i, wr_new[i]); end
            checks++; if (wr_cyc[i] != 9 + i) begin errors++; $display("FAIL busy_cycle%0d got %0d exp %0d", i, wr_cyc[i], 9 + i); end
        end
        checks++; if (nRowsUsed !== 17'd6) begin errors++; $display("FAIL busy_nRowsUsed got %0d exp 6", nRowsUsed); end
    endtask

    task automatic test_overflow;
        do_reset();
        src.delete();
        for (int i = 100; i <= 116; i++) src.push_back(i);
        src.push_back(103);
        stream(0, 25);
        checks++; if (wr_row.size() != 17) begin errors++; $display("FAIL ovf_count got %0d exp 17", wr_row.size()); end
        for (int i = 0; i < 16 && i < wr_row.size(); i++) begin
            checks++; if (wr_row[i] != i || wr_new[i] !== 1'b1) begin errors++; $display("FAIL ovf_row%0d got %0d/%0d exp %0d/1", i, wr_row[i], wr_new[i], i); end
        end
        if (wr_row.size() == 17) begin
            checks++; if (wr_row[16] != 3) begin errors++; $display("FAIL ovf_rehit_row got %0d exp 3", wr_row[16]); end
            checks++; if (wr_new[16] !== 1'b0) begin errors++; $display("FAIL ovf_rehit_new got %0d exp 0", wr_new[16]); end
            checks++; if (wr_cyc[16] != 19) begin errors++; $display("FAIL ovf_rehit_cycle got %0d exp 19", wr_cyc[16]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0d exp 1", overflow); end
        checks++; if (nRowsUsed !== 17'd16) begin errors++; $display("FAIL ovf_nRowsUsed got %0d exp 16", nRowsUsed); end
    endtask

    // Starts from the full, overflowed table left by test_overflow.
    task automatic test_event_end;
        int n_wr = 0, pulses = 0;
        logic [16:0] rows_at = '1;
        logic ovf_at = 1'b1;
        @(negedge clk) begin hcmBusy = 1'b1; SSIDValid = 1'b1; SSIDIn = 16'd101; end
        @(negedge clk) SSIDIn = 16'd102;
        @(negedge clk) begin SSIDValid = 1'b0; eventEnd = 1'b1; end
        @(negedge clk) eventEnd = 1'b0;
        checks++; if (SSIDReady !== 1'b0) begin errors++; $display("FAIL drain_ready got %0d exp 0", SSIDReady); end
        hcmBusy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (writeRow) begin
                checks++;
                if (n_wr > 1 || int'(rowToWrite) != n_wr + 1 || SSIDIsNew !== 1'b0) begin
                    errors++; $display("FAIL drain_write%0d got row %0d new %0d exp row %0d new 0", n_wr, rowToWrite, SSIDIsNew, n_wr + 1);
                end
                n_wr++;
            end
            if (eventDone) begin
                if (pulses == 0) begin rows_at = nRowsUsed; ovf_at = overflow; end
                pulses++;
            end
        end
        checks++; if (n_wr != 2) begin errors++; $display("FAIL drain_writes got %0d exp 2", n_wr); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL eventDone_pulses got %0d exp 1", pulses); end
        checks++; if (rows_at !== 17'd0) begin errors++; $display("FAIL clear_nRowsUsed got %0d exp 0", rows_at); end
        checks++; if (ovf_at !== 1'b0) begin errors++; $display("FAIL clear_overflow got %0d exp 0", ovf_at); end
        src = '{9, 101};
        stream(0, 8);
        checks++; if (wr_row.size() != 2) begin errors++; $display("FAIL post_clear_count got %0d exp 2", wr_row.size()); end
        for (int i = 0; i < 2 && i < wr_row.size(); i++) begin
            checks++; if (wr_row[i] != i || wr_new[i] !== 1'b1) begin errors++; $display("FAIL post_clear_row%0d got %0d/%0d exp %0d/1", i, wr_row[i], wr_new[i], i); end
        end
    endtask

    task automatic test_reset_drain;
        int n_wr = 0, pulses = 0;
        @(negedge clk) begin hcmBusy = 1'b1; SSIDValid = 1'b1; SSIDIn = 16'd11; end
        @(negedge clk) SSIDIn = 16'd12;
        @(negedge clk) SSIDIn = 16'd13;
        @(negedge clk) begin SSIDValid = 1'b0; eventEnd = 1'b1; end
        @(negedge clk) eventEnd = 1'b0;
        checks++; if (SSIDReady !== 1'b0) begin errors++; $display("FAIL rdrain_ready got %0d exp 0", SSIDReady); end
        reset = 1'b0;
        #1;
        checks++; if (nRowsUsed !== 17'd0) begin errors++; $display("FAIL rdrain_async_nRowsUsed got %0d exp 0", nRowsUsed); end
        @(negedge clk) begin reset = 1'b1; hcmBusy = 1'b0; end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (writeRow) n_wr++;
            if (eventDone) pulses++;
        end
        checks++; if (n_wr != 0) begin errors++; $display("FAIL rdrain_writes got %0d exp 0", n_wr); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rdrain_eventDone got %0d exp 0", pulses); end
        src = '{5, 9};
        stream(0, 8);
        checks++; if (wr_row.size() != 2) begin errors++; $display("FAIL rdrain_post_count got %0d exp 2", wr_row.size()); end
        for (int i = 0; i < 2 && i < wr_row.size(); i++) begin
            checks++; if (wr_row[i] != i || wr_new[i] !== 1'b1) begin errors++; $display("FAIL rdrain_post_row%0d got %0d/%0d exp %0d/1", i, wr_row[i], wr_new[i], i); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy();
        test_overflow();
        test_event_end();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
